// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage in front of the L1 instruction cache. It owns the
// word-addressed PC, drives the registered cache read address, captures the
// returned words (tagged with their PC) into a small FIFO, and presents the
// FIFO head to decode over a valid/ready handshake. A redirect from execute
// flushes the FIFO and any request in flight.
//
// Parameters
//   RESET_PC   word address fetched first after reset
//   BUF_DEPTH  instruction FIFO entries (power of two, 2..8)
//
// Ports
//   i_clk           clock
//   i_rst           asynchronous, active-high reset
//   i_clk_en        global enable (shared with the cache); low holds all state
//   o_cache_addr    registered word address to the cache
//   i_cache_data    cache read data
//   i_cache_ready   qualifies i_cache_data
//   i_redirect      one-cycle branch/jump redirect pulse from execute
//   i_redirect_pc   redirect target word address
//   o_instr_valid   FIFO non-empty
//   i_instr_ready   decode accepts the head entry
//   o_instr         head instruction word
//   o_instr_pc      word address of the head instruction
//
// Optional feature (macro FETCH_JPREDECODE_EN)
//   When defined, a pushed J word (opcode 6'b000010) steers the next fetch to
//   its target (cache_data[15:0]) instead of the sequential address.
//
// Request slot FSM
//   state  | meaning
//   S_IDLE | no cache request in flight
//   S_WAIT | one request in flight for r_inflight_pc
// -----------------------------------------------------------------------------
module fetch_unit #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_clk_en,
   output logic [15:0] o_cache_addr,
   input  logic [31:0] i_cache_data,
   input  logic        i_cache_ready,
   input  logic        i_redirect,
   input  logic [15:0] i_redirect_pc,
   output logic        o_instr_valid,
   input  logic        i_instr_ready,
   output logic [31:0] o_instr,
   output logic [15:0] o_instr_pc
);

   localparam int PW = (BUF_DEPTH <= 2) ? 1 : (BUF_DEPTH <= 4) ? 2 : 3;
   localparam int CW = PW + 1;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_WAIT = 1'b1
   } state_t;

   state_t          r_state;
   state_t          w_state_n;
   logic [15:0]     r_addr;
   logic [15:0]     w_addr_n;
   logic [15:0]     r_inflight_pc;
   logic [15:0]     w_inflight_n;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_count_n;
   logic [PW-1:0]   r_rd_ptr;
   logic [PW-1:0]   r_wr_ptr;
   logic [31:0]     r_mem_data [BUF_DEPTH];
   logic [15:0]     r_mem_pc   [BUF_DEPTH];
   logic            w_push;
   logic            w_pop;
   logic            w_flush;
   logic            w_is_j;

   assign o_cache_addr  = r_addr;
   assign o_instr_valid = (r_count != '0);
   assign o_instr       = r_mem_data[r_rd_ptr];
   assign o_instr_pc    = r_mem_pc[r_rd_ptr];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else if (i_clk_en) begin
         r_state <= w_state_n;
      end
   end

   always_comb begin
      w_state_n    = S_IDLE;
      w_addr_n     = r_addr;
      w_inflight_n = r_inflight_pc;
      w_push       = 1'b0;
      w_flush      = 1'b0;
      w_is_j       = 1'b0;
      w_pop        = o_instr_valid && i_instr_ready;
      w_count_n    = r_count - CW'(w_pop);

      if (i_redirect) begin
         w_flush   = 1'b1;
         w_count_n = '0;
         w_addr_n  = i_redirect_pc;
      end else if ((r_state == S_WAIT) && !i_cache_ready) begin
         // Cache missed the slot: re-present the in-flight address next edge.
         w_addr_n = r_inflight_pc;
      end else begin
         w_push    = (r_state == S_WAIT);
         w_count_n = r_count - CW'(w_pop) + CW'(w_push);
`ifdef FETCH_JPREDECODE_EN
         w_is_j    = w_push && (i_cache_data[31:26] == 6'b000010);
`endif
         if (w_is_j) begin
            w_addr_n = i_cache_data[15:0];
         end else if (w_count_n < CW'(BUF_DEPTH)) begin
            // Only issue when the returning word is guaranteed a FIFO slot.
            w_state_n    = S_WAIT;
            w_inflight_n = r_addr;
            w_addr_n     = r_addr + 16'd1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_addr        <= RESET_PC;
         r_inflight_pc <= '0;
         r_count       <= '0;
         r_rd_ptr      <= '0;
         r_wr_ptr      <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            r_mem_data[i] <= '0;
            r_mem_pc[i]   <= '0;
         end
      end else if (i_clk_en) begin
         r_addr        <= w_addr_n;
         r_inflight_pc <= w_inflight_n;
         r_count       <= w_count_n;
         if (w_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
         end else begin
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_push) begin
               r_mem_data[r_wr_ptr] <= i_cache_data;
               r_mem_pc[r_wr_ptr]   <= r_inflight_pc;
               r_wr_ptr             <= r_wr_ptr + PW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [15:0] RPC = 16'h0010;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        clk_en = 1'b1;
   logic [15:0] cache_addr;
   logic [31:0] cache_data = 32'd0;
   logic        cache_ready = 1'b1;
   logic        redirect = 1'b0;
   logic [15:0] redirect_pc = 16'd0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instr;
   logic [15:0] instr_pc;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] exp_pc = RPC;

   fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(2)) dut (
      .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
      .o_cache_addr(cache_addr), .i_cache_data(cache_data),
      .i_cache_ready(cache_ready), .i_redirect(redirect),
      .i_redirect_pc(redirect_pc), .o_instr_valid(instr_valid),
      .i_instr_ready(instr_ready), .o_instr(instr), .o_instr_pc(instr_pc)
   );

   always #5 clk = ~clk;

   // Program image: word i = 0x1000_0000+i, except a J to 0x0020 at 0x0005.
   function automatic logic [31:0] word(input logic [15:0] a);
      if (a == 16'h0005) return {6'b000010, 10'd0, 16'h0020};
      return 32'h1000_0000 + {16'd0, a};
   endfunction

   // Architectural successor of an instruction in delivery order.
   function automatic logic [15:0] nxt(input logic [15:0] a);
      logic [31:0] w;
      w = word(a);
`ifdef FETCH_JPREDECODE_EN
      if (w[31:26] == 6'b000010) return w[15:0];
`endif
      return a + 16'd1;
   endfunction

   always @(posedge clk) if (clk_en) cache_data <= word(cache_addr);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endtask

   // Model: decode must see the program stream in order, starting at RESET_PC
   // or at a redirect target, with no gap, duplicate or stale entry.
   always @(negedge clk) begin
      if (rst) begin
         exp_pc = RPC;
      end else begin
         if (instr_valid) begin
            chk("stream_pc", {16'd0, instr_pc}, {16'd0, exp_pc});
            chk("stream_data", instr, word(exp_pc));
         end
         if (clk_en) begin
            if (redirect) exp_pc = redirect_pc;
            else if (instr_valid && instr_ready) exp_pc = nxt(exp_pc);
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      // Reset values
      step(); step();
      chk("rst_addr",  {16'd0, cache_addr}, {16'd0, RPC});
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr, 32'd0);
      chk("rst_pc",    {16'd0, instr_pc}, 32'd0);
      rst = 1'b0;

      // First fetch latency and steady stream
      step();
      chk("e1_valid", {31'd0, instr_valid}, 32'd0);
      chk("e1_addr",  {16'd0, cache_addr}, 32'h0011);
      step();
      chk("e2_valid", {31'd0, instr_valid}, 32'd1);
      chk("e2_pc",    {16'd0, instr_pc}, 32'h0010);
      chk("e2_instr", instr, 32'h1000_0010);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("run_valid", {31'd0, instr_valid}, 32'd1);
      end
      chk("run_pc",   {16'd0, instr_pc}, 32'h0014);

      // clk_en low freezes everything
      clk_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("frz_addr",  {16'd0, cache_addr}, 32'h0016);
         chk("frz_pc",    {16'd0, instr_pc}, 32'h0014);
         chk("frz_valid", {31'd0, instr_valid}, 32'd1);
      end
      clk_en = 1'b1;

      // Backpressure: FIFO saturates, address holds
      instr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_addr", {16'd0, cache_addr}, 32'h0016);
         chk("bp_pc",   {16'd0, instr_pc}, 32'h0014);
      end
      instr_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("rel_valid", {31'd0, instr_valid}, 32'd1);
      end
      chk("rel_pc", {16'd0, instr_pc}, 32'h0018);

      // Redirect with a push pending and a request in flight
      instr_ready = 1'b0;
      redirect = 1'b1; redirect_pc = 16'h0030;
      step();
      redirect = 1'b0; instr_ready = 1'b1;
      chk("rd0_valid", {31'd0, instr_valid}, 32'd0);
      chk("rd0_addr",  {16'd0, cache_addr}, 32'h0030);
      step();
      chk("rd1_valid", {31'd0, instr_valid}, 32'd0);
      step();
      chk("rd2_valid", {31'd0, instr_valid}, 32'd1);
      chk("rd2_pc",    {16'd0, instr_pc}, 32'h0030);
      chk("rd2_instr", instr, 32'h1000_0030);

      // Replay on a missed cache slot
      step();
      chk("pre_rp_pc", {16'd0, instr_pc}, 32'h0031);
      cache_ready = 1'b0;
      step();
      cache_ready = 1'b1;
      chk("rp_addr",  {16'd0, cache_addr}, 32'h0032);
      chk("rp_valid", {31'd0, instr_valid}, 32'd0);
      step();
      step();
      chk("rp_pc", {16'd0, instr_pc}, 32'h0032);

      // 16-bit wrap
      redirect = 1'b1; redirect_pc = 16'hFFFE;
      step();
      redirect = 1'b0;
      step(); step();
      chk("wr_pc0", {16'd0, instr_pc}, 32'hFFFE);
      step();
      chk("wr_pc1", {16'd0, instr_pc}, 32'hFFFF);
      step();
      chk("wr_pc2", {16'd0, instr_pc}, 32'h0000);

      // J at 0x0005
      redirect = 1'b1; redirect_pc = 16'h0004;
      step();
      redirect = 1'b0;
      step(); step();
      chk("j_pc4", {16'd0, instr_pc}, 32'h0004);
      step();
      chk("j_pc5", {16'd0, instr_pc}, 32'h0005);
      step();
      n = 1;
      while (!instr_valid && n < 6) begin
         step();
         n++;
      end
      chk("j_wait_valid", {31'd0, instr_valid}, 32'd1);
`ifdef FETCH_JPREDECODE_EN
      chk("j_next_pc", {16'd0, instr_pc}, 32'h0020);
`else
      chk("j_next_pc", {16'd0, instr_pc}, 32'h0006);
`endif

      // Mid-operation reset
      rst = 1'b1;
      #1;
      chk("mr_valid", {31'd0, instr_valid}, 32'd0);
      chk("mr_addr",  {16'd0, cache_addr}, {16'd0, RPC});
      chk("mr_pc",    {16'd0, instr_pc}, 32'd0);
      chk("mr_instr", instr, 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("mr1_valid", {31'd0, instr_valid}, 32'd0);
      step();
      chk("mr2_pc", {16'd0, instr_pc}, {16'd0, RPC});
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage sitting directly upstream of the L1 instruction cache. It owns the word-addressed program counter and drives the cache read address. It captures returned words into a small FIFO tagged with their PC and presents them to decode over a valid/ready handshake. Redirects from execute flush all speculative fetch state.

## Interface
- RESET_PC, 16'h0000, word address fetched first after reset
- BUF_DEPTH, 2, instruction FIFO entries; power of two, 2..8
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- clk_en  in  1  global enable, the same signal that gates the cache; low holds all state
- cache_addr  out  16  word address to cache, registered (addr_q)
- cache_data  in  32  cache read data
- cache_ready  in  1  cache data_ready; qualifies cache_data
- redirect  in  1  execute-resolved branch/jump, one-cycle pulse
- redirect_pc  in  16  redirect target word address
- instr_valid  out  1  FIFO non-empty
- instr_ready  in  1  decode accepts head entry
- instr  out  32  head instruction word
- instr_pc  out  16  word address of head instruction

## Operation
- Cache model: at an enabled edge the cache samples cache_addr; the word is on cache_data after that edge, qualified by cache_ready.
- Request slot FSM, in flight flag plus inflight_pc:
  - IDLE: nothing in flight.
  - WAIT: one request in flight for inflight_pc.
- All events are evaluated at enabled edges only. Priority is highest first:
  1. redirect: clear FIFO (count=0), go IDLE, addr_q<=redirect_pc. No push, no issue.
  2. WAIT and !cache_ready: replay. Go IDLE, addr_q<=inflight_pc.
  3. Normal operation:
     - push = WAIT && cache_ready, writing {cache_data, inflight_pc}.
     - pop = instr_valid && instr_ready.
     - issue when count-pop+push < BUF_DEPTH: go WAIT, inflight_pc<=addr_q, addr_q<=addr_q+1.
     - no issue: go IDLE, addr_q holds. The data the cache returns for the held address is ignored.
- Push and pop in the same edge are legal, including when the FIFO is full: the count is unchanged.
- PC arithmetic is 16-bit modulo. 16'hFFFF+1 = 16'h0000.
- Reset values:
  - cache_addr=RESET_PC
  - instr_valid=0
  - instr=0
  - instr_pc=0
  - FSM=IDLE
  - count=0
- instr/instr_pc are don't-care while instr_valid=0, except at reset.
- Reset asserted mid-operation discards FIFO contents and any in-flight request immediately.
- A pop in the redirect cycle is considered consumed by decode; the rest of the FIFO is discarded.

## Timing
- Reset release to first instr_valid: 2 enabled edges.
  - Edge 1 issues RESET_PC.
  - Edge 2 pushes it.
- Redirect edge to first valid target instruction: 2 further enabled edges.
- Steady state with instr_ready held high gives 1 instruction per enabled cycle when BUF_DEPTH>=2.
- FIFO full with instr_ready low: no issue. Fetch resumes on the edge of the first pop.
- clk_en low freezes everything, including the handshake outputs.

## Configuration
- FETCH_JPREDECODE_EN defined:
  - On a push whose cache_data[31:26]==6'b000010 (J), the word is still pushed.
  - The same edge replaces the issue step with: go IDLE, addr_q<=cache_data[15:0].
  - The sequential request is thereby killed, and instructions resume at the target after 2 edges.
  - Execute must be built with the same macro and must not redirect for J.
- Undefined:
  - J words are fetched sequentially like any other instruction.
  - Execute's redirect performs the jump.

## Test plan
- Reset, RESET_PC=16'h0010, cache word i = 32'h1000_0000+i, instr_ready=1 -> valid after 2 edges. instr_pc is 0x0010, 0x0011, 0x0012… on consecutive cycles, with matching data.
- instr_ready low for 5 cycles with BUF_DEPTH=2 -> count saturates at 2 and cache_addr holds. On release the PCs continue in order with no gap or duplicate.
- redirect to 16'h0030 while the FIFO is full and a request is in flight -> the next valid instr_pc is 0x0030, 2 edges later, and no stale PC appears.
- cache_ready forced low for one cycle in WAIT -> the address is replayed and the PC sequence is unbroken.
- addr_q at 16'hFFFE with sequential run -> instr_pc sequence FFFE, FFFF, 0000.
- With FETCH_JPREDECODE_EN, a J at 0x0005 with target 0x0020 -> instr_pc sequence 0x0005 then 0x0020; 0x0006 is never delivered. Without the macro, 0x0006 follows.
